// File: rtl/output_writer_pkg.sv
// Shared definitions for the output_writer block: FSM state encoding, the
// default output-region base address, and a small width helper.
package output_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_OUTPUT_BASE = 32'h0000_3000;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Row FIFO: one entry per output row. Pointers wrap at DEPTH, which need not
// be a power of two. Besides the head it exposes the entry behind the head so
// the writer can start the next row at the same edge that pops the current one.
module row_fifo
  import output_writer_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int DEPTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           next_head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head      = mem[rd_ptr];
  assign next_head = mem[ptr_inc(rd_ptr)];

  // Storage array write.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_writer.sv
// output_writer: captures valid rows from the systolic array into a row FIFO
// and serialises them as single-word writes at OUTPUT_BASE + row*K + col.
// Optional feature macro: OUTPUT_WRITER_RELU_EN clamps negative words to zero
// at the output register (latency unchanged).
module output_writer
  import output_writer_pkg::*;
#(
  parameter int                    M           = 20,
  parameter int                    K           = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(DEFAULT_OUTPUT_BASE),
  parameter int                    FIFO_DEPTH  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH*K-1:0] Y,
  input  logic                    valid,
  output logic [ADDR_WIDTH-1:0]   addr_wr,
  output logic [DATA_WIDTH-1:0]   data_wr,
  output logic                    mem_wr_en,
  output logic                    done,
  output logic                    overflow
);

  localparam int RW    = $clog2(M + 1);
  localparam int COL_W = idx_width(K);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ROW_BITS = DATA_WIDTH * K;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [RW-1:0]      row;
  logic [RW-1:0]      rows_in;

  logic [ROW_BITS-1:0] f_head;
  logic [ROW_BITS-1:0] f_next;
  logic                f_full;
  logic                f_empty;
  logic [CNT_W-1:0]    f_count;

  logic                push;
  logic                pop;
  logic                drop;
  logic                accept_ok;
  logic                last_col;
  logic                last_row;

  logic                  issue;
  logic [ROW_BITS-1:0]   issue_src;
  logic [COL_W-1:0]      issue_col;
  logic [RW-1:0]         issue_row;
  logic [DATA_WIDTH-1:0] issue_word;
  logic [DATA_WIDTH-1:0] issue_data;
  logic [ADDR_WIDTH-1:0] issue_addr;

  row_fifo #(
    .WIDTH (ROW_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (Y),
    .head      (f_head),
    .next_head (f_next),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  assign last_col  = (col == COL_W'(K - 1));
  assign last_row  = (row == RW'(M - 1));
  // The head row leaves the FIFO on the edge that issues nothing more from it.
  assign pop       = (state == WRITE) && last_col;
  assign accept_ok = valid && (rows_in < RW'(M));
  assign push      = accept_ok && (!f_full || pop);
  assign drop      = accept_ok && f_full && !pop;

  // Choose the word (if any) to load into the output registers at the next edge.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    issue     = 1'b0;
    issue_src = f_head;
    issue_col = '0;
    issue_row = row;
    case (state)
      IDLE: issue = !f_empty;
      WRITE: begin
        if (!last_col) begin
          issue     = 1'b1;
          issue_col = col + 1'b1;
        end else if (!last_row && (f_count > CNT_W'(1))) begin
          issue     = 1'b1;
          issue_src = f_next;
          issue_row = row + 1'b1;
        end
      end
      default: issue = 1'b0;
    endcase
    issue_word = issue_src[int'(issue_col)*DATA_WIDTH +: DATA_WIDTH];
`ifdef OUTPUT_WRITER_RELU_EN
    issue_data = issue_word[DATA_WIDTH-1] ? '0 : issue_word;
`else
    issue_data = issue_word;
`endif
    issue_addr = OUTPUT_BASE
               + ADDR_WIDTH'(issue_row) * ADDR_WIDTH'(K)
               + ADDR_WIDTH'(issue_col);
  end

  // Writer FSM, counters, sticky flags and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      rows_in   <= '0;
      addr_wr   <= '0;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      if (push) rows_in  <= rows_in + 1'b1;
      if (drop) overflow <= 1'b1;

      mem_wr_en <= issue;
      if (issue) begin
        addr_wr <= issue_addr;
        data_wr <= issue_data;
        col     <= issue_col;
      end

      case (state)
        IDLE: begin
          if (!f_empty) state <= WRITE;
        end
        WRITE: begin
          if (last_col) begin
            row <= row + 1'b1;
            if (last_row) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!issue) begin
              state <= IDLE;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
